// File: rtl/iter_alu.sv
// ---------------------------------------------------------------------------
// iter_alu -- registered ALU with iterative multiply/divide.
//
// Single-cycle ops (ADD..PASS_B) load result/zero at the start edge and pulse
// done in the following cycle. MUL/MULHU/DIV/DIVU/REMU run WIDTH shift-add or
// restoring-divide iterations, so the core FSM must stall on busy.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous, active-high reset (aborts any op in flight)
//   start   in   launch op; sampled only while busy=0
//   op      in   [3:0] operation select
//                0 ADD  1 SUB  2 OR   3 AND  4 XOR  5 SLT  6 SLTU  7 SLL
//                8 SRL  9 SRA  10 PASS_B  11 MUL  12 MULHU  13 DIV
//                14 DIVU  15 REMU
//   src_a   in   [WIDTH-1:0] operand A
//   src_b   in   [WIDTH-1:0] operand B (shift amount = low $clog2(WIDTH) bits)
//   busy    out  high in every state except IDLE
//   done    out  one-cycle pulse; result valid from this cycle on
//   result  out  [WIDTH-1:0] registered result, held until the next done
//   zero    out  registered (result == 0)
//
// Parameters: WIDTH (>= 4, even), CNT_W (derived, do not override).
//
// Optional build macro ITER_ALU_EARLY_OUT_EN: multiplies with a zero operand
// and divides by zero finish with single-cycle latency instead of running
// the full iteration sequence.
// ---------------------------------------------------------------------------
module iter_alu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam int SH_W = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_SUB    = 4'd1;
   localparam logic [3:0] OP_OR     = 4'd2;
   localparam logic [3:0] OP_AND    = 4'd3;
   localparam logic [3:0] OP_XOR    = 4'd4;
   localparam logic [3:0] OP_SLT    = 4'd5;
   localparam logic [3:0] OP_SLTU   = 4'd6;
   localparam logic [3:0] OP_SLL    = 4'd7;
   localparam logic [3:0] OP_SRL    = 4'd8;
   localparam logic [3:0] OP_SRA    = 4'd9;
   localparam logic [3:0] OP_PASS_B = 4'd10;
   localparam logic [3:0] OP_MUL    = 4'd11;
   localparam logic [3:0] OP_MULHU  = 4'd12;
   localparam logic [3:0] OP_DIV    = 4'd13;
   localparam logic [3:0] OP_DIVU   = 4'd14;
   localparam logic [3:0] OP_REMU   = 4'd15;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------------
   function automatic logic is_iter(input logic [3:0] f_op);
      return f_op >= OP_MUL;
   endfunction

   function automatic logic is_mul(input logic [3:0] f_op);
      return (f_op == OP_MUL) || (f_op == OP_MULHU);
   endfunction

   function automatic logic is_div(input logic [3:0] f_op);
      return (f_op == OP_DIV) || (f_op == OP_DIVU) || (f_op == OP_REMU);
   endfunction

   // Two's-complement negation, wrapping modulo 2^WIDTH (so -MIN == MIN).
   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
      return (~x) + WIDTH'(1);
   endfunction

   function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
      logic [WIDTH-1:0] ux;
      ux = x;
      return x[WIDTH-1] ? negate(ux) : ux;
   endfunction

   function automatic logic [WIDTH-1:0] alu_single(input logic [3:0]       f_op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
      logic signed [WIDTH-1:0] sa;
      logic signed [WIDTH-1:0] sb;
      logic [SH_W-1:0]         sh;
      logic [WIDTH-1:0]        r;
      sa = a;
      sb = b;
      sh = b[SH_W-1:0];
      r  = '0;
      case (f_op)
         OP_ADD:    r = a + b;
         OP_SUB:    r = a - b;
         OP_OR:     r = a | b;
         OP_AND:    r = a & b;
         OP_XOR:    r = a ^ b;
         OP_SLT:    r = {{(WIDTH-1){1'b0}}, (sa < sb)};
         OP_SLTU:   r = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLL:    r = a << sh;
         OP_SRL:    r = a >> sh;
         OP_SRA:    r = sa >>> sh;
         OP_PASS_B: r = b;
         default:   r = '0;
      endcase
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [3:0]          op_r;
   logic [2*WIDTH-1:0]  prod;    // {partial sum, remaining multiplier bits}
   logic [WIDTH-1:0]    opnd;    // multiplicand, or divisor magnitude
   logic [WIDTH-1:0]    quo;     // dividend bits shifting out, quotient shifting in
   logic [WIDTH-1:0]    rem;     // restored remainder; always < divisor, so WIDTH bits hold it
   logic                neg_q;   // negate quotient in FIX (signed DIV only)

   logic                idle_load;
   logic                iter_launch;
   logic                early_hit;
   logic [WIDTH-1:0]    idle_val;

   logic [WIDTH:0]      mul_sum;
   logic [2*WIDTH-1:0]  prod_step;
   logic [WIDTH:0]      div_trial;
   logic                div_fits;
   logic [WIDTH-1:0]    div_diff;
   logic [WIDTH-1:0]    rem_step;
   logic [WIDTH-1:0]    quo_step;
   logic [WIDTH-1:0]    fix_val;

   // ------------------------------------------------------------------------
   // IDLE: single-cycle result and optional early-out selection
   // ------------------------------------------------------------------------
   always_comb begin
      idle_val  = alu_single(op, src_a, src_b);
      early_hit = 1'b0;
`ifdef ITER_ALU_EARLY_OUT_EN
      if (is_mul(op) && ((src_a == '0) || (src_b == '0))) begin
         early_hit = 1'b1;
         idle_val  = '0;
      end else if (is_div(op) && (src_b == '0)) begin
         early_hit = 1'b1;
         idle_val  = (op == OP_REMU) ? src_a : '1;
      end
`endif
   end

   // ------------------------------------------------------------------------
   // CALC: one multiply or divide iteration per cycle
   // ------------------------------------------------------------------------
   always_comb begin
      // Shift-add, LSB-first: add multiplicand into the upper half when the
      // current multiplier bit is set, then shift the whole product right.
      mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
      prod_step = {mul_sum, prod[WIDTH-1:1]};

      // Restoring divide, MSB-first. The trial remainder is WIDTH+1 bits; when
      // it fits, the true difference is below the divisor, so the low WIDTH
      // bits of the subtraction are exact. A zero divisor always "fits",
      // which yields an all-ones quotient and remainder == dividend.
      div_trial = {rem, quo[WIDTH-1]};
      div_fits  = div_trial >= {1'b0, opnd};
      div_diff  = div_trial[WIDTH-1:0] - opnd;
      rem_step  = div_fits ? div_diff : div_trial[WIDTH-1:0];
      quo_step  = {quo[WIDTH-2:0], div_fits};
   end

   // ------------------------------------------------------------------------
   // FIX: pick the requested half / quotient / remainder
   // ------------------------------------------------------------------------
   always_comb begin
      case (op_r)
         OP_MUL:   fix_val = prod[WIDTH-1:0];
         OP_MULHU: fix_val = prod[2*WIDTH-1:WIDTH];
         OP_DIV:   fix_val = neg_q ? negate(quo) : quo;
         OP_DIVU:  fix_val = quo;
         default:  fix_val = rem;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      busy        = 1'b1;
      done        = 1'b0;
      idle_load   = 1'b0;
      iter_launch = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (is_iter(op) && !early_hit) begin
                  iter_launch = 1'b1;
                  state_nxt   = S_CALC;
               end else begin
                  idle_load   = 1'b1;
                  state_nxt   = S_DONE;
               end
            end
         end
         // Iterations run while cnt < WIDTH; the cycle that sees cnt == WIDTH
         // moves on, giving a fixed WIDTH+2 edges from start to done.
         S_CALC: begin
            if (cnt == CNT_W'(WIDTH)) begin
               state_nxt = S_FIX;
            end
         end
         S_FIX: begin
            state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
         zero   <= 1'b1;
         cnt    <= '0;
         op_r   <= '0;
         prod   <= '0;
         opnd   <= '0;
         quo    <= '0;
         rem    <= '0;
         neg_q  <= 1'b0;
      end else begin
         if (idle_load) begin
            result <= idle_val;
            zero   <= (idle_val == '0);
         end

         if (iter_launch) begin
            cnt  <= '0;
            op_r <= op;
            prod <= {{WIDTH{1'b0}}, src_b};
            rem  <= '0;
            if (is_mul(op)) begin
               opnd <= src_a;
            end else if (op == OP_DIV) begin
               opnd <= abs_val(src_b);
            end else begin
               opnd <= src_b;
            end
            quo <= (op == OP_DIV) ? abs_val(src_a) : src_a;
            // No sign fix on divide-by-zero: the all-ones quotient stands.
            neg_q <= (op == OP_DIV) && (src_a[WIDTH-1] ^ src_b[WIDTH-1]) &&
                     (src_b != '0);
         end

         if ((state == S_CALC) && (cnt != CNT_W'(WIDTH))) begin
            cnt <= cnt + CNT_W'(1);
            if (is_mul(op_r)) begin
               prod <= prod_step;
            end else begin
               rem <= rem_step;
               quo <= quo_step;
            end
         end

         if (state == S_FIX) begin
            result <= fix_val;
            zero   <= (fix_val == '0);
         end
      end
   end

endmodule

// File: tb/tb_iter_alu.sv
module tb_iter_alu;

   localparam int W  = 32;
   localparam int SH = $clog2(W);
   localparam int ML = W + 2;
`ifdef ITER_ALU_EARLY_OUT_EN
   localparam bit EO_EN = 1'b1;
`else
   localparam bit EO_EN = 1'b0;
`endif
   localparam int EO = EO_EN ? 0 : ML;

   localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  OR_ = 4'd2,  AND_ = 4'd3;
   localparam logic [3:0] XOR_ = 4'd4, SLT = 4'd5,  SLTU = 4'd6, SLL = 4'd7;
   localparam logic [3:0] SRL = 4'd8,  SRA = 4'd9,  PASSB = 4'd10, MUL = 4'd11;
   localparam logic [3:0] MULHU = 4'd12, DIV = 4'd13, DIVU = 4'd14, REMU = 4'd15;

   logic         clk;
   logic         rst;
   logic         start;
   logic [3:0]   op;
   logic [W-1:0] src_a;
   logic [W-1:0] src_b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         zero;

   int checks = 0;
   int errors = 0;

   iter_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .busy(busy), .done(done), .result(result), .zero(zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference behaviour straight from the op definitions.
   function automatic logic [W-1:0] ref_result(input logic [3:0] f, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
      logic [2*W-1:0] p;
      longint         sa, sb, q;
      logic [63:0]    qv;
      logic [SH-1:0]  sh;
      p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = b[SH-1:0];
      case (f)
         ADD:   return a + b;
         SUB:   return a - b;
         OR_:   return a | b;
         AND_:  return a & b;
         XOR_:  return a ^ b;
         SLT:   return (sa < sb) ? W'(1) : W'(0);
         SLTU:  return (a < b) ? W'(1) : W'(0);
         SLL:   return a << sh;
         SRL:   return a >> sh;
         SRA:   return W'($signed(a) >>> sh);
         PASSB: return b;
         MUL:   return p[W-1:0];
         MULHU: return p[2*W-1:W];
         DIV: begin
            if (b == '0) return '1;
            q  = sa / sb;
            qv = q;
            return qv[W-1:0];
         end
         DIVU:  return (b == '0) ? '1 : a / b;
         default: return (b == '0) ? a : a % b;
      endcase
   endfunction

   // Clock edges from the accepting edge to the edge that raises done.
   function automatic int ref_lat(input logic [3:0] f, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      logic eo_hit;
      eo_hit = ((f == MUL || f == MULHU) && (a == '0 || b == '0)) ||
               (f >= DIV && b == '0);
      if (f < MUL) return 0;
      if (EO_EN && eo_hit) return 0;
      return ML;
   endfunction

   // Cycle-level model: idle / in flight (edges left) / done.
   logic         m_busy = 1'b0;
   logic         m_done = 1'b0;
   logic         m_zero = 1'b1;
   logic [W-1:0] m_res  = '0;
   logic [W-1:0] m_pend = '0;
   int           m_left = 0;
   logic         chk_en = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_res  <= '0;
         m_zero <= 1'b1;
         m_left <= 0;
         chk_en <= 1'b1;
      end else if (m_done) begin
         m_done <= 1'b0;
         m_busy <= 1'b0;
      end else if (m_busy) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_done <= 1'b1;
            m_res  <= m_pend;
            m_zero <= (m_pend == '0);
         end
      end else if (start) begin
         m_busy <= 1'b1;
         m_pend <= ref_result(op, src_a, src_b);
         m_left <= ref_lat(op, src_a, src_b);
         if (ref_lat(op, src_a, src_b) == 0) begin
            m_done <= 1'b1;
            m_res  <= ref_result(op, src_a, src_b);
            m_zero <= (ref_result(op, src_a, src_b) == '0);
         end
      end
   end

   task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("model busy", W'(busy), W'(m_busy));
         cmp("model done", W'(done), W'(m_done));
         cmp("model result", result, m_res);
         cmp("model zero", W'(zero), W'(m_zero));
      end
   end

   // Drive one start cycle, then scramble inputs to show they are not re-read.
   task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(negedge clk);
      start = 1'b0; op = ~o; src_a = ~a; src_b = b ^ 32'h5A5A_A5A5;
   endtask

   task automatic wait_done(input string name, input logic [W-1:0] exp_res, input int exp_lat,
                            input int n0);
      int n;
      n = n0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s timeout: no done after %0d cycles, expected latency %0d",
                  name, n, exp_lat);
      end else begin
         cmp({name, " latency"}, W'(n), W'(exp_lat));
         cmp({name, " result"}, result, exp_res);
         cmp({name, " zero"}, W'(zero), W'(exp_res == '0));
      end
   endtask

   task automatic run_op(input string name, input logic [3:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_res, input int exp_lat);
      issue(o, a, b);
      wait_done(name, exp_res, exp_lat, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      rst = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
      repeat (2) @(negedge clk);
      cmp("reset result", result, '0);
      cmp("reset zero", W'(zero), W'(1));
      cmp("reset busy", W'(busy), W'(0));
      cmp("reset done", W'(done), W'(0));
      rst = 1'b0;

      run_op("add",   ADD,  32'd5,          32'd7,          32'd12,         0);
      run_op("sub",   SUB,  32'h6,          32'h6,          32'h0,          0);
      run_op("sra",   SRA,  32'h8000_0000,  32'd4,          32'hF800_0000,  0);
      run_op("sltu",  SLTU, 32'd1,          32'hFFFF_FFFF,  32'd1,          0);
      run_op("slt",   SLT,  32'd1,          32'hFFFF_FFFF,  32'd0,          0);
      run_op("xor",   XOR_, 32'hF0F0_1234,  32'h0FF0_1234,  32'hFF00_0000,  0);
      run_op("sll",   SLL,  32'd1,          32'd33,         32'd2,          0);
      run_op("srl",   SRL,  32'h8000_0000,  32'd31,         32'd1,          0);
      run_op("passb", PASSB,32'h1111_1111,  32'hCAFE_F00D,  32'hCAFE_F00D,  0);
      run_op("mul",   MUL,  32'h0001_0003,  32'h0000_0010,  32'h0010_0030,  ML);
      run_op("mulhu", MULHU,32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  ML);
      run_op("div",   DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  ML);
      run_op("div2",  DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  ML);
      run_op("divu",  DIVU, 32'd100,        32'd7,          32'd14,         ML);
      run_op("remu",  REMU, 32'd100,        32'd7,          32'd2,          ML);
      run_op("remu2", REMU, 32'd7,          32'd100,        32'd7,          ML);
      run_op("divu0", DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  EO);
      run_op("remu0", REMU, 32'd5,          32'd0,          32'd5,          EO);
      run_op("divn0", DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  EO);
      run_op("divov", DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  ML);
      run_op("mul0",  MUL,  32'd0,          32'd5,          32'd0,          EO);

      // start during an in-flight DIVU must be ignored
      issue(DIVU, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      start = 1'b1; op = ADD; src_a = 32'd1; src_b = 32'd2;
      cmp("ignore busy", W'(busy), W'(1));
      @(negedge clk);
      start = 1'b0;
      cmp("ignore still busy", W'(busy), W'(1));
      cmp("ignore no done", W'(done), W'(0));
      wait_done("divu ignore", 32'd14, ML, 11);

      // reset in the middle of a MUL aborts it
      issue(MUL, 32'h0001_0003, 32'h0000_0010);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cmp("abort busy", W'(busy), W'(0));
      cmp("abort result", result, '0);
      cmp("abort zero", W'(zero), W'(1));
      seen = 0;
      repeat (ML + 6) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      cmp("abort no done", W'(seen), W'(0));

      run_op("after abort", ADD, 32'hFFFF_FFFF, 32'd2, 32'd1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
